// File: rtl/pipeline_defs.sv
// pipeline_defs: funct codes, mul/div FSM states and default widths shared by the pipeline stages.
package pipeline_defs;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    typedef enum logic [5:0] {
        F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
        F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
        F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B,
        F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23,
        F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27,
        F_SLT  = 6'h2A, F_SLTU = 6'h2B
    } funct_e;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier / restoring divider owning HI and LO.
// The divider datapath exists only when EX_DIV_EN is defined.
module mul_div_unit
    import pipeline_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CW = $clog2(DATA_W);
    md_state_e state;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] acc_hi, acc_lo, m, step_hi, step_lo, fin_hi, fin_lo;
    logic [DATA_W:0] sum;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic neg_q, go, a_neg, b_neg;
    assign a_neg = !op[0] && a[DATA_W-1];
    assign b_neg = !op[0] && b[DATA_W-1];
    assign busy = state != MD_IDLE;
    assign done = state == MD_DONE;
    assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    assign prod = {sum, acc_lo[DATA_W-1:1]};
    assign prod_fix = neg_q ? -prod : prod;
`ifdef EX_DIV_EN
    logic is_div, neg_r, dz;
    logic [DATA_W:0] shifted;
    logic [DATA_W+1:0] diff;
    assign go = start && !flush && state == MD_IDLE;
    assign shifted = {acc_hi, acc_lo[DATA_W-1]};
    assign diff = {1'b0, shifted} - {2'b0, m};
    assign step_hi = is_div ? (diff[DATA_W+1] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0]) : prod[2*DATA_W-1:DATA_W];
    assign step_lo = is_div ? {acc_lo[DATA_W-2:0], !diff[DATA_W+1]} : prod[DATA_W-1:0];
    // Divide by zero leaves the dividend magnitude in the remainder, so the sign fix-up restores raw a.
    assign fin_hi = is_div ? (neg_r ? -step_hi : step_hi) : prod_fix[2*DATA_W-1:DATA_W];
    assign fin_lo = is_div ? (dz ? '1 : (neg_q ? -step_lo : step_lo)) : prod_fix[DATA_W-1:0];
`else
    assign go = start && !flush && !op[1] && state == MD_IDLE;
    assign step_hi = prod[2*DATA_W-1:DATA_W];
    assign step_lo = prod[DATA_W-1:0];
    assign fin_hi = prod_fix[2*DATA_W-1:DATA_W];
    assign fin_lo = prod_fix[DATA_W-1:0];
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            m <= '0;
            neg_q <= 1'b0;
`ifdef EX_DIV_EN
            is_div <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
`endif
        end else begin
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
            case (state)
                MD_IDLE: if (go) begin
                    state <= MD_BUSY;
                    cnt <= '0;
                    acc_hi <= '0;
                    neg_q <= a_neg ^ b_neg;
`ifdef EX_DIV_EN
                    is_div <= op[1];
                    neg_r <= a_neg;
                    dz <= b == '0;
                    m <= op[1] ? (b_neg ? -b : b) : (a_neg ? -a : a);
                    acc_lo <= op[1] ? (a_neg ? -a : a) : (b_neg ? -b : b);
`else
                    m <= a_neg ? -a : a;
                    acc_lo <= b_neg ? -b : b;
`endif
                end
                MD_BUSY: if (flush) state <= MD_IDLE;
                else begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) begin
                        state <= MD_DONE;
                        hi <= fin_hi;
                        lo <= fin_lo;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage -- ALU, destination mux and stall control around mul_div_unit.
// DIV/DIVU reach the divider only when EX_DIV_EN is defined.
module ex_stage
    import pipeline_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              flush,
    input  logic [5:0]        alu_op,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] sign_extend,
    input  logic [REG_W-1:0]  reg1,
    input  logic [REG_W-1:0]  reg2,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_W-1:0]  write_reg,
    output logic              ovf,
    output logic              stall,
    output logic              md_busy
);
    logic [DATA_W-1:0] opb, add_r, sub_r, hi, lo;
    logic [4:0] shamt;
    logic is_md, start, md_done;
    assign opb = alu_src ? sign_extend : data2;
    assign shamt = sign_extend[10:6];
    assign add_r = data1 + opb;
    assign sub_r = data1 - opb;
    assign store_data = data2;
    assign write_reg = reg_dst ? reg2 : reg1;
`ifdef EX_DIV_EN
    assign is_md = alu_op[5:2] == 4'b0110;
`else
    assign is_md = alu_op[5:1] == 5'b01100;
`endif
    assign start = ex_valid && !flush && is_md;
    // Busy-but-not-done covers both the running op and any HI/LO access waiting behind it.
    assign stall = (start && !md_busy) || (md_busy && !md_done);
    mul_div_unit #(.DATA_W(DATA_W)) u_md (
        .clk(clk), .rst(rst), .start(start), .op(alu_op[1:0]), .a(data1), .b(data2),
        .flush(flush),
        .hi_we(ex_valid && !stall && !flush && alu_op == F_MTHI),
        .lo_we(ex_valid && !stall && !flush && alu_op == F_MTLO),
        .busy(md_busy), .done(md_done), .hi(hi), .lo(lo)
    );
    always_comb begin
        alu_result = '0;
        ovf = 1'b0;
        case (alu_op)
            F_SLL:  alu_result = opb << shamt;
            F_SRL:  alu_result = opb >> shamt;
            F_SRA:  alu_result = $signed(opb) >>> shamt;
            F_MFHI: alu_result = hi;
            F_MFLO: alu_result = lo;
            F_ADD: begin
                alu_result = add_r;
                ovf = data1[DATA_W-1] == opb[DATA_W-1] && add_r[DATA_W-1] != data1[DATA_W-1];
            end
            F_ADDU: alu_result = add_r;
            F_SUB: begin
                alu_result = sub_r;
                ovf = data1[DATA_W-1] != opb[DATA_W-1] && sub_r[DATA_W-1] != data1[DATA_W-1];
            end
            F_SUBU: alu_result = sub_r;
            F_AND:  alu_result = data1 & opb;
            F_OR:   alu_result = data1 | opb;
            F_XOR:  alu_result = data1 ^ opb;
            F_NOR:  alu_result = ~(data1 | opb);
            F_SLT:  alu_result = DATA_W'($signed(data1) < $signed(opb));
            F_SLTU: alu_result = DATA_W'(data1 < opb);
            default: alu_result = '0;
        endcase
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage; exercises the divider when EX_DIV_EN is defined.
module tb_ex_stage;
    import pipeline_defs::*;
    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        ovf;
        logic [4:0]  wr;
        logic [31:0] sd;
    } exp_t;
    localparam longint MAXI = 64'sh7FFFFFFF;
    localparam longint MINI = -64'sh80000000;
    logic clk = 1'b0, rst = 1'b1, ex_valid = 1'b0, flush = 1'b0, alu_src = 1'b0, reg_dst = 1'b0;
    logic [5:0] alu_op = '0;
    logic [31:0] data1 = '0, data2 = '0, sign_extend = '0;
    logic [4:0] reg1 = '0, reg2 = '0;
    logic [31:0] alu_result, store_data;
    logic [4:0] write_reg;
    logic ovf, stall, md_busy;
    logic [31:0] ref_hi = '0, ref_lo = '0;
    exp_t sb[$];
    int n_vec = 0, n_err = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush), .alu_op(alu_op),
        .alu_src(alu_src), .reg_dst(reg_dst), .data1(data1), .data2(data2),
        .sign_extend(sign_extend), .reg1(reg1), .reg2(reg2), .alu_result(alu_result),
        .store_data(store_data), .write_reg(write_reg), .ovf(ovf), .stall(stall), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        longint s;
        case (op)
            F_SLL:  return {1'b0, b << sh};
            F_SRL:  return {1'b0, b >> sh};
            F_SRA:  return {1'b0, 32'($signed(b) >>> sh)};
            F_MFHI: return {1'b0, ref_hi};
            F_MFLO: return {1'b0, ref_lo};
            F_ADD, F_SUB: begin
                s = op == F_ADD ? longint'($signed(a)) + longint'($signed(b)) : longint'($signed(a)) - longint'($signed(b));
                return {s > MAXI || s < MINI, s[31:0]};
            end
            F_ADDU: return {1'b0, a + b};
            F_SUBU: return {1'b0, a - b};
            F_AND:  return {1'b0, a & b};
            F_OR:   return {1'b0, a | b};
            F_XOR:  return {1'b0, a ^ b};
            F_NOR:  return {1'b0, ~(a | b)};
            F_SLT:  return {32'b0, $signed(a) < $signed(b)};
            F_SLTU: return {32'b0, a < b};
            default: return '0;
        endcase
    endfunction

    task automatic ref_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] u;
        case (op)
            F_MULT: begin p = longint'($signed(a)) * longint'($signed(b)); {ref_hi, ref_lo} = p; end
            F_MULTU: begin u = {32'b0, a} * {32'b0, b}; {ref_hi, ref_lo} = u; end
`ifdef EX_DIV_EN
            F_DIV: if (b == 0) begin ref_lo = '1; ref_hi = a; end
                   else begin ref_lo = $signed(a) / $signed(b); ref_hi = $signed(a) % $signed(b); end
            F_DIVU: if (b == 0) begin ref_lo = '1; ref_hi = a; end
                    else begin ref_lo = a / b; ref_hi = a % b; end
`endif
            F_MTHI: ref_hi = a;
            F_MTLO: ref_lo = a;
            default: ;
        endcase
    endtask

    // Called just after a rising edge; returns just after the edge that retires the instruction.
    task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] se = 32'd0, input logic src = 1'b0, input int exp_stall = 0);
        exp_t e;
        logic [32:0] r;
        int n;
        reg1 = 5'($urandom);
        reg2 = 5'($urandom);
        reg_dst = 1'($urandom);
        data1 = d1;
        data2 = d2;
        sign_extend = se;
        alu_src = src;
        alu_op = op;
        ex_valid = 1'b1;
        flush = 1'b0;
        r = ref_alu(op, d1, src ? se : d2, se[10:6]);
        e = '{tag, r[31:0], r[32], reg_dst ? reg2 : reg1, d2};
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, ".stall"}, 64'(n), 64'(exp_stall));
        e = sb.pop_front();
        check({e.tag, ".res"}, {32'b0, alu_result}, {32'b0, e.res});
        check({e.tag, ".ovf"}, {63'b0, ovf}, {63'b0, e.ovf});
        check({e.tag, ".wr"}, {59'b0, write_reg}, {59'b0, e.wr});
        check({e.tag, ".sd"}, {32'b0, store_data}, {32'b0, e.sd});
        ref_md(op, d1, d2);
        @(posedge clk);
        #1;
    endtask

    logic [5:0] alu_ops [14] = '{F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB, F_SUBU,
                                 F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, 6'h3F};

    initial begin
        #12;
        check("rst.stall", {63'b0, stall}, 64'd0);
        check("rst.busy", {63'b0, md_busy}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue("rst_mfhi", F_MFHI, 0, 0);
        issue("rst_mflo", F_MFLO, 0, 0);
        issue("add_ovf", F_ADD, 32'h7FFFFFFF, 32'h1);
        issue("addu_noovf", F_ADDU, 32'h7FFFFFFF, 32'h1);
        issue("sub_ovf", F_SUB, 32'h80000000, 32'h1);
        issue("addi", F_ADD, 32'd10, 32'hDEAD, 32'hFFFFFFF6, 1'b1);
        issue("slt", F_SLT, 32'hFFFFFFFF, 32'h1);
        issue("sltu", F_SLTU, 32'hFFFFFFFF, 32'h1);
        issue("sra", F_SRA, 32'h0, 32'h80000000, 32'd4 << 6);
        issue("badop", 6'h3E, 32'h1234, 32'h5678);
        for (int i = 0; i < 24; i++)
            issue("rnd_alu", alu_ops[$urandom_range(0, 13)], $urandom, $urandom, $urandom, 1'($urandom));
        issue("mult", F_MULT, 32'hFFFFFFFE, 32'd3, 0, 1'b0, 33);
        issue("mfhi_mult", F_MFHI, 0, 0);
        issue("mflo_mult", F_MFLO, 0, 0);
        issue("multu", F_MULTU, 32'd10, 32'd10, 0, 1'b0, 33);
        issue("mflo_multu", F_MFLO, 0, 0);
        for (int i = 0; i < 3; i++) begin
            issue("rnd_mul", i[0] ? F_MULTU : F_MULT, $urandom, $urandom, 0, 1'b0, 33);
            issue("rnd_mfhi", F_MFHI, 0, 0);
            issue("rnd_mflo", F_MFLO, 0, 0);
        end
`ifdef EX_DIV_EN
        issue("div", F_DIV, -32'sd7, 32'd2, 0, 1'b0, 33);
        issue("div_mflo", F_MFLO, 0, 0);
        issue("div_mfhi", F_MFHI, 0, 0);
        issue("divu0", F_DIVU, 32'd5, 32'd0, 0, 1'b0, 33);
        issue("divu0_mflo", F_MFLO, 0, 0);
        issue("divu0_mfhi", F_MFHI, 0, 0);
        issue("div0s", F_DIV, -32'sd9, 32'd0, 0, 1'b0, 33);
        issue("div0s_mfhi", F_MFHI, 0, 0);
        issue("divneg", F_DIV, 32'd100, -32'sd7, 0, 1'b0, 33);
        issue("divneg_mflo", F_MFLO, 0, 0);
        issue("divneg_mfhi", F_MFHI, 0, 0);
`else
        issue("div_off", F_DIV, 32'd8, 32'd2);
        issue("divu_off", F_DIVU, 32'd8, 32'd2);
        issue("div_off_mfhi", F_MFHI, 0, 0);
        issue("div_off_mflo", F_MFLO, 0, 0);
`endif
        issue("mthi", F_MTHI, 32'h12345678, 0);
        issue("mtlo", F_MTLO, 32'h9ABCDEF0, 0);
        issue("mt_mfhi", F_MFHI, 0, 0);
        issue("mt_mflo", F_MFLO, 0, 0);
        // Flush on BUSY cycle 10 of a multiply.
        alu_op = F_MULT;
        data1 = 32'd5;
        data2 = 32'd7;
        ex_valid = 1'b1;
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush.stall_hold", {63'b0, stall}, 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        check("flush.busy", {63'b0, md_busy}, 64'd0);
        check("flush.stall", {63'b0, stall}, 64'd0);
        @(posedge clk);
        #1;
        issue("flush_mfhi", F_MFHI, 0, 0);
        issue("flush_mflo", F_MFLO, 0, 0);
        // Flush and start together: flush wins.
        alu_op = F_MULTU;
        data1 = 32'd3;
        data2 = 32'd3;
        ex_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flstart.stall", {63'b0, stall}, 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        check("flstart.busy", {63'b0, md_busy}, 64'd0);
        @(posedge clk);
        #1;
        issue("flstart_mflo", F_MFLO, 0, 0);
        // Asynchronous reset in the middle of a multiply.
        alu_op = F_MULT;
        data1 = 32'd9;
        data2 = 32'd9;
        ex_valid = 1'b1;
        repeat (5) @(posedge clk);
        #3 ex_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst.stall", {63'b0, stall}, 64'd0);
        check("arst.busy", {63'b0, md_busy}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ref_hi = '0;
        ref_lo = '0;
        issue("arst_mfhi", F_MFHI, 0, 0);
        issue("arst_mflo", F_MFLO, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
